ram_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of the 128 KB SPRAM block (4x SB_SPRAM256KA, 16-bit words).

---
 rtl/ram_arbiter_if.sv | 13 +
 rtl/ram_arbiter.sv | 104 ++++++++++
 tb/tb_ram_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: single-word RAM access port between one requester and the arbiter.
interface ram_arbiter_if #(parameter int DATA_W = 16);
    logic              req;
    logic              we;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              err;
    modport master (output req, we, addr, wdata, input ack, rdata, rvalid, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, rvalid, err);
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter serialising single-word accesses to the SPRAM block.
// Define RAM_ARB_ADDR_CHECK_EN to reject addresses beyond ADDR_W bits with a pN_err pulse.
module ram_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    ram_arbiter_if.slave      p0,
    ram_arbiter_if.slave      p1,
    output logic [31:0]       mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read
);
`ifdef RAM_ARB_ADDR_CHECK_EN
    localparam bit ADDR_CHECK = 1'b1;
`else
    localparam bit ADDR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t            state;
    logic              last_grant;
    logic              grant;
    logic              cmd_rd;
    logic              sel;
    logic              s_we;
    logic              bad;
    logic [31:0]       s_addr;
    logic [DATA_W-1:0] s_wdata;

    // A lone requester wins outright; on a tie the port that did not win last time goes.
    always_comb begin
        sel     = (p0.req & p1.req) ? ~last_grant : p1.req;
        s_we    = sel ? p1.we : p0.we;
        s_addr  = sel ? p1.addr : p0.addr;
        s_wdata = sel ? p1.wdata : p0.wdata;
        bad     = ADDR_CHECK && (s_addr[31:ADDR_W] != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            grant          <= 1'b0;
            cmd_rd         <= 1'b0;
            mem_addr       <= '0;
            mem_wr_en      <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_data_write <= '0;
            p0.ack         <= 1'b0;
            p0.err         <= 1'b0;
            p0.rvalid      <= 1'b0;
            p0.rdata       <= '0;
            p1.ack         <= 1'b0;
            p1.err         <= 1'b0;
            p1.rvalid      <= 1'b0;
            p1.rdata       <= '0;
        end else begin
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            p0.ack    <= 1'b0;
            p0.err    <= 1'b0;
            p0.rvalid <= 1'b0;
            p1.ack    <= 1'b0;
            p1.err    <= 1'b0;
            p1.rvalid <= 1'b0;
            unique case (state)
                IDLE: if (p0.req || p1.req) begin
                    // Command is registered straight onto the RAM bus so it is live during ISSUE.
                    state      <= ISSUE;
                    grant      <= sel;
                    last_grant <= sel;
                    cmd_rd     <= ~s_we & ~bad;
                    mem_wr_en  <= s_we & ~bad;
                    mem_rd_en  <= ~s_we & ~bad;
                    p0.ack     <= ~sel;
                    p1.ack     <= sel;
                    p0.err     <= ~sel & bad;
                    p1.err     <= sel & bad;
                    if (!bad) begin
                        mem_addr       <= s_addr;
                        mem_data_write <= s_wdata;
                    end
                end
                ISSUE: state <= cmd_rd ? RD_WAIT : IDLE;
                RD_WAIT: begin
                    state <= IDLE;
                    if (grant) begin
                        p1.rdata  <= mem_data_read;
                        p1.rvalid <= 1'b1;
                    end else begin
                        p0.rdata  <= mem_data_read;
                        p0.rvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors for ram_arbiter against a registered-read RAM model.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [15:0] mem_data_write;
    logic [15:0] mem_data_read = '0;
    logic [15:0] ram [0:65535];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          model_last = 1'b1;

    ram_arbiter_if #(.DATA_W(16)) i0 ();
    ram_arbiter_if #(.DATA_W(16)) i1 ();

    ram_arbiter #(.ADDR_W(17), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .p0(i0), .p1(i1),
        .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
        .mem_data_write(mem_data_write), .mem_data_read(mem_data_read)
    );

    always #5 clk = ~clk;

    // SPRAM behaviour: word-addressed, read data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr[16:1]] <= mem_data_write;
        if (mem_rd_en) mem_data_read <= ram[mem_addr[16:1]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (!reset) chk("wr_rd_exclusive", {31'd0, mem_wr_en & mem_rd_en}, 32'd0);

    task automatic set_cmd(input bit p, input bit req, input bit we, input logic [31:0] a, input logic [15:0] d);
        if (p) begin
            i1.req = req; i1.we = we; i1.addr = a; i1.wdata = d;
        end else begin
            i0.req = req; i0.we = we; i0.addr = a; i0.wdata = d;
        end
    endtask

    function automatic logic ack_of(input bit p);
        return p ? i1.ack : i0.ack;
    endfunction

    function automatic logic err_of(input bit p);
        return p ? i1.err : i0.err;
    endfunction

    function automatic logic rv_of(input bit p);
        return p ? i1.rvalid : i0.rvalid;
    endfunction

    function automatic logic [15:0] rd_of(input bit p);
        return p ? i1.rdata : i0.rdata;
    endfunction

    task automatic do_access(input bit p, input bit we, input logic [31:0] a,
                             input logic [15:0] d, input bit exp_err);
        @(negedge clk);
        set_cmd(p, 1'b1, we, a, d);
        @(negedge clk);
        chk("ack", {31'd0, ack_of(p)}, 32'd1);
        chk("other_ack", {31'd0, ack_of(~p)}, 32'd0);
        chk("err", {31'd0, err_of(p)}, {31'd0, exp_err});
        chk("wr_en", {31'd0, mem_wr_en}, {31'd0, we & ~exp_err});
        chk("rd_en", {31'd0, mem_rd_en}, {31'd0, ~we & ~exp_err});
        if (!exp_err) chk("mem_addr", mem_addr, a);
        if (we && !exp_err) chk("mem_wdata", {16'd0, mem_data_write}, {16'd0, d});
        set_cmd(p, 1'b0, 1'b0, '0, '0);
        model_last = p;
        if (!we) begin
            @(negedge clk);
            chk("rvalid_early", {31'd0, rv_of(p)}, 32'd0);
            chk("rd_en_pulse", {31'd0, mem_rd_en}, 32'd0);
            @(negedge clk);
            chk("rvalid", {31'd0, rv_of(p)}, {31'd0, ~exp_err});
            chk("other_rvalid", {31'd0, rv_of(~p)}, 32'd0);
            if (!exp_err) chk("rdata", {16'd0, rd_of(p)}, {16'd0, d});
        end else begin
            @(negedge clk);
            chk("wr_en_pulse", {31'd0, mem_wr_en}, 32'd0);
        end
    endtask

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int k0, k1, cyc;
        bit g, exp_g;
        vecs[0] = '{1'b0, 1'b1, 32'h0_0010, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b0, 32'h0_0010, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b1, 32'h0_7FFE, 16'h1111};
        vecs[3] = '{1'b1, 1'b1, 32'h0_8000, 16'h2222};
        vecs[4] = '{1'b0, 1'b1, 32'h1_FFFE, 16'h3333};
        vecs[5] = '{1'b1, 1'b1, 32'h1_0000, 16'h4444};
        vecs[6] = '{1'b1, 1'b0, 32'h0_7FFE, 16'h1111};
        vecs[7] = '{1'b0, 1'b0, 32'h0_8000, 16'h2222};
        vecs[8] = '{1'b1, 1'b0, 32'h1_FFFE, 16'h3333};
        vecs[9] = '{1'b0, 1'b0, 32'h1_0000, 16'h4444};
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0);
        set_cmd(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        chk("rst_acks", {30'd0, i0.ack, i1.ack}, 32'd0);
        chk("rst_rvalid", {30'd0, i0.rvalid, i1.rvalid}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) do_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b0);

        // Both ports hammer writes; grants must alternate and match the winning port's command.
        k0 = 0; k1 = 0; cyc = 0;
        @(negedge clk);
        set_cmd(1'b0, 1'b1, 1'b1, 32'h100, 16'hA000);
        set_cmd(1'b1, 1'b1, 1'b1, 32'h200, 16'hB000);
        while ((k0 < 8 || k1 < 8) && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (i0.ack || i1.ack) begin
                exp_g = (k0 < 8 && k1 < 8) ? ~model_last : (k0 >= 8);
                g = i1.ack;
                chk("rr_grant", {31'd0, g}, {31'd0, exp_g});
                chk("rr_single_ack", {31'd0, i0.ack & i1.ack}, 32'd0);
                chk("rr_mem_addr", mem_addr, g ? 32'h200 + 2 * k1 : 32'h100 + 2 * k0);
                chk("rr_wdata", {16'd0, mem_data_write}, g ? 32'hB000 + k1 : 32'hA000 + k0);
                chk("rr_wr_en", {31'd0, mem_wr_en}, 32'd1);
                model_last = g;
                if (g) begin
                    k1++;
                    set_cmd(1'b1, k1 < 8, 1'b1, 32'h200 + 2 * k1, 16'hB000 + 16'(k1));
                end else begin
                    k0++;
                    set_cmd(1'b0, k0 < 8, 1'b1, 32'h100 + 2 * k0, 16'hA000 + 16'(k0));
                end
            end
        end
        chk("rr_done", k0 + k1, 32'd16);
        chk("rr_cycles", {31'd0, cyc <= 34}, 32'd1);
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0);
        set_cmd(1'b1, 1'b0, 1'b0, '0, '0);
        do_access(1'b1, 1'b0, 32'h20E, 16'hB007, 1'b0);
        do_access(1'b0, 1'b0, 32'h10E, 16'hA007, 1'b0);

        // Reset lands while the p0 read waits for RAM data; the result must be dropped.
        @(negedge clk);
        set_cmd(1'b0, 1'b1, 1'b0, 32'h10, 16'h0);
        @(negedge clk);
        chk("rw_ack", {31'd0, i0.ack}, 32'd1);
        set_cmd(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rw_rst_addr", mem_addr, 32'd0);
        chk("rw_rst_en", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        chk("rw_rst_rdata", {16'd0, i0.rdata}, 32'd0);
        chk("rw_rst_flags", {29'd0, i0.ack, i0.rvalid, i0.err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rw_no_rvalid", {31'd0, i0.rvalid}, 32'd0);
        end
        do_access(1'b1, 1'b0, 32'h10, 16'hBEEF, 1'b0);

`ifdef RAM_ARB_ADDR_CHECK_EN
        do_access(1'b0, 1'b0, 32'h2_0000, 16'h0, 1'b1);
`else
        do_access(1'b0, 1'b1, 32'h2_0000, 16'h5555, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
